// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word per PC, holds it for the control
// stage until exec_done, then advances to the PC the control stage supplies.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nrst,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid_out,
    input  logic [31:0] pc_next_in,
    input  logic        exec_done_in,
    output logic        misalign_out,
    output logic        bus_err_out,
    output logic [31:0] instret_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_TRAP = 2'd3;

    // Value the wait counter holds during the last permitted request cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;

    assign imem_addr_out = pc_out;

    // imem_req_out is registered alongside state so it is high exactly in S_REQ.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= S_IDLE;
            pc_out          <= RESET_PC;
            instr_out       <= '0;
            instr_valid_out <= 1'b0;
            imem_req_out    <= 1'b0;
            misalign_out    <= 1'b0;
            bus_err_out     <= 1'b0;
            instret_out     <= '0;
            wait_cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state        <= S_REQ;
                    imem_req_out <= 1'b1;
                    wait_cnt     <= '0;
                end
                S_REQ: begin
                    if (imem_ack_in) begin
                        instr_out       <= imem_data_in;
                        instr_valid_out <= 1'b1;
                        imem_req_out    <= 1'b0;
                        state           <= S_EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus_err_out  <= 1'b1;
                        imem_req_out <= 1'b0;
                        state        <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (exec_done_in) begin
                        instr_valid_out <= 1'b0;
                        if (pc_next_in[1:0] == 2'b00) begin
                            pc_out       <= pc_next_in;
                            instret_out  <= instret_out + 32'd1;
                            imem_req_out <= 1'b1;
                            wait_cnt     <= '0;
                            state        <= S_REQ;
                        end else begin
                            misalign_out <= 1'b1;
                            state        <= S_TRAP;
                        end
                    end
                end
                default: begin
                    state <= S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for the normal/misalign flow,
// hand sequences for wait states, async reset, instret wrap and timeout.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        nrst;
    logic        ack, done;
    logic [31:0] data, pcn;
    logic        req, valid, mis, berr;
    logic [31:0] addr, pc, instr, instret;

    logic        t_nrst, t_ack, t_done;
    logic [31:0] t_data, t_pcn;
    logic        t_req, t_valid, t_mis, t_berr;
    logic [31:0] t_addr, t_pc, t_instr, t_instret;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .nrst(nrst), .imem_req_out(req), .imem_addr_out(addr),
        .imem_ack_in(ack), .imem_data_in(data), .pc_out(pc), .instr_out(instr),
        .instr_valid_out(valid), .pc_next_in(pcn), .exec_done_in(done),
        .misalign_out(mis), .bus_err_out(berr), .instret_out(instret)
    );

    fetch_unit #(.RESET_PC(32'h0000_1000), .TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .nrst(t_nrst), .imem_req_out(t_req), .imem_addr_out(t_addr),
        .imem_ack_in(t_ack), .imem_data_in(t_data), .pc_out(t_pc), .instr_out(t_instr),
        .instr_valid_out(t_valid), .pc_next_in(t_pcn), .exec_done_in(t_done),
        .misalign_out(t_mis), .bus_err_out(t_berr), .instret_out(t_instret)
    );

    typedef struct {
        logic        ack;
        logic [31:0] data;
        logic        done;
        logic [31:0] pcn;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_instret;
        logic        e_mis;
        logic        e_berr;
    } vec_t;

    localparam logic [31:0] D0 = 32'h0000_0013;
    localparam logic [31:0] D1 = 32'h0040_0093;
    localparam logic [31:0] D2 = 32'h0080_0113;
    localparam logic [31:0] D3 = 32'h00C0_0193;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_main(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_instret,
                            input logic e_mis, input logic e_berr);
        chk({tag, ".req"}, {31'd0, req}, {31'd0, e_req});
        chk({tag, ".addr"}, addr, e_addr);
        chk({tag, ".pc"}, pc, e_addr);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
        chk({tag, ".instret"}, instret, e_instret);
        chk({tag, ".misalign"}, {31'd0, mis}, {31'd0, e_mis});
        chk({tag, ".bus_err"}, {31'd0, berr}, {31'd0, e_berr});
    endtask

    task automatic chk_t(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic e_berr);
        chk({tag, ".req"}, {31'd0, t_req}, {31'd0, e_req});
        chk({tag, ".addr"}, t_addr, e_addr);
        chk({tag, ".valid"}, {31'd0, t_valid}, {31'd0, e_valid});
        chk({tag, ".bus_err"}, {31'd0, t_berr}, {31'd0, e_berr});
    endtask

    initial begin
        // ack data done pcn | req addr valid instr instret misalign bus_err
        vecs[0]  = '{1'b0, 32'h0, 1'b0, 32'h0,     1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, D0,    1'b0, 32'h0,     1'b1, 32'h0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0, 1'b1, 32'h4,     1'b0, 32'h0, 1'b1, D0,    32'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, D1,    1'b0, 32'h0,     1'b1, 32'h4, 1'b0, 32'h0, 32'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 32'h8,     1'b0, 32'h4, 1'b1, D1,    32'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, D2,    1'b0, 32'h0,     1'b1, 32'h8, 1'b0, 32'h0, 32'd2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 32'hC,     1'b0, 32'h8, 1'b1, D2,    32'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, D3,    1'b0, 32'h0,     1'b1, 32'hC, 1'b0, 32'h0, 32'd3, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 32'h102,   1'b0, 32'hC, 1'b1, D3,    32'd3, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, D0,    1'b1, 32'h4,     1'b0, 32'hC, 1'b0, 32'h0, 32'd3, 1'b1, 1'b0};
        vecs[10] = '{1'b1, D1,    1'b1, 32'h8,     1'b0, 32'hC, 1'b0, 32'h0, 32'd3, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 32'h0,     1'b0, 32'hC, 1'b0, 32'h0, 32'd3, 1'b1, 1'b0};

        nrst = 1'b0; ack = 1'b0; done = 1'b0; data = '0; pcn = '0;
        t_nrst = 1'b0; t_ack = 1'b0; t_done = 1'b0; t_data = '0; t_pcn = '0;
        repeat (2) @(negedge clk);
        chk_main("reset", 1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("reset.instr", instr, 32'h0);
        chk_t("t_reset", 1'b0, 32'h0000_1000, 1'b0, 1'b0);

        // Normal fetch/retire at full rate, then a misaligned pc_next traps.
        nrst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            chk_main(tag, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                     vecs[i].e_instret, vecs[i].e_mis, vecs[i].e_berr);
            if (vecs[i].e_valid) chk({tag, ".instr"}, instr, vecs[i].e_instr);
            ack = vecs[i].ack; data = vecs[i].data;
            done = vecs[i].done; pcn = vecs[i].pcn;
            @(negedge clk);
        end

        // Ack delayed by five cycles: request and address held for six cycles.
        ack = 1'b0; done = 1'b0; nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            string tag;
            tag = $sformatf("wait%0d", k);
            chk_main(tag, 1'b1, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
            ack = (k == 5);
            data = (k == 5) ? 32'hCAFE_F00D : 32'h1111_1111 * k;
            @(negedge clk);
        end
        ack = 1'b0; data = '0;
        chk_main("wait_done", 1'b0, 32'h0, 1'b1, 32'd0, 1'b0, 1'b0);
        chk("wait_done.instr", instr, 32'hCAFE_F00D);

        // Move to S_EXEC at pc 0x40, then pulse reset mid-cycle.
        done = 1'b1; pcn = 32'h40;
        @(negedge clk);
        done = 1'b0; ack = 1'b1; data = D2;
        chk_main("to40", 1'b1, 32'h40, 1'b0, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        ack = 1'b0;
        chk_main("exec40", 1'b0, 32'h40, 1'b1, 32'd1, 1'b0, 1'b0);
        #2 nrst = 1'b0;
        #1;
        chk_main("async_rst", 1'b0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("async_rst.instr", instr, 32'h0);
        @(negedge clk);
        nrst = 1'b1; ack = 1'b1; data = 32'hBAD0_BAD0; done = 1'b1; pcn = 32'h80;
        @(negedge clk);
        chk_main("stray", 1'b1, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("stray.instr", instr, 32'h0);
        done = 1'b0; ack = 1'b1; data = D1;
        @(negedge clk);
        ack = 1'b0;
        chk_main("refetch", 1'b0, 32'h0, 1'b1, 32'd0, 1'b0, 1'b0);
        chk("refetch.instr", instr, D1);

        // instret wraps to zero on the next retirement without raising a flag.
        force dut.instret_out = 32'hFFFF_FFFF;
        #1 release dut.instret_out;
        done = 1'b1; pcn = 32'h4;
        @(negedge clk);
        done = 1'b0;
        chk_main("wrap", 1'b1, 32'h4, 1'b0, 32'd0, 1'b0, 1'b0);

        // Timeout instance: four unacked request cycles raise bus_err.
        t_nrst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk_t($sformatf("to_req%0d", k), 1'b1, 32'h0000_1000, 1'b0, 1'b0);
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            t_ack = 1'b1; t_done = 1'b1; t_pcn = 32'h0000_1004;
            chk_t($sformatf("to_trap%0d", k), 1'b0, 32'h0000_1000, 1'b0, 1'b1);
            @(negedge clk);
        end
        t_ack = 1'b0; t_done = 1'b0;
        chk_t("to_trap_hold", 1'b0, 32'h0000_1000, 1'b0, 1'b1);
        chk("to_trap.misalign", {31'd0, t_mis}, 32'd0);

        // Ack on the fourth request cycle wins over the timeout.
        t_nrst = 1'b0;
        @(negedge clk);
        t_nrst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk_t($sformatf("late_req%0d", k), 1'b1, 32'h0000_1000, 1'b0, 1'b0);
            t_ack = (k == 3); t_data = 32'h0123_4567;
            @(negedge clk);
        end
        t_ack = 1'b0;
        chk_t("late_exec", 1'b0, 32'h0000_1000, 1'b1, 1'b0);
        chk("late_exec.instr", t_instr, 32'h0123_4567);
        t_done = 1'b1; t_pcn = 32'h0000_1004;
        @(negedge clk);
        t_done = 1'b0;
        chk_t("late_next", 1'b1, 32'h0000_1004, 1'b0, 1'b0);
        chk("late_next.instret", t_instret, 32'd1);
        chk("late_next.pc", t_pc, 32'h0000_1004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
